seq_divider: RTL and testbench
==============================

# seq_divider

Sequential 32-bit unsigned non-restoring divider. It is the initiator side of the 33-bit add/subtract datapath: each cycle it chooses the operation (add or subtract divisor) from the sign of the partial remainder, drives the adder-subtractor, and consumes its result. It sits beside the adder-subtractor unit in the arithmetic block, behind a start/done handshake owned by the ALU control.

## Interface

- `WIDTH`, default 32: dividend, divisor, quotient and remainder width. The partial remainder is `WIDTH+1` bits.
- `clk` (input, 1): single clock; all state updates on the rising edge.
- `rst` (input, 1): asynchronous, active-high reset.
- `start` (input, 1): request a division. Accepted only when `busy`=0.
- `dividend` (input, WIDTH): numerator, sampled on the accepting edge.
- `divisor` (input, WIDTH): denominator, sampled on the accepting edge.
- `busy` (output, 1): high from the accepting edge until `done` is deasserted.
- `done` (output, 1): one-cycle pulse; results are valid while it is high.
- `quotient` (output, WIDTH): result. Holds its value until the next accepted start.
- `remainder` (output, WIDTH): result. Holds its value until the next accepted start.
- `div_by_zero` (output, 1): flag. Valid with `done` and held with the results.

## Operation

- **States:** IDLE, RUN, FIX, DONE.
- **IDLE**
  - When `start` is high, latch D = `divisor`, A = `dividend`, P = 0 (33-bit signed), count = 0.
  - If `divisor`=0, go to DONE with quotient = all ones, remainder = `dividend`, `div_by_zero`=1.
  - Otherwise go to RUN with `div_by_zero`=0.
- **RUN (one iteration per cycle, 32 cycles)**
  - Shift {P, A} left by 1 bit.
  - If the pre-shift P[32] is 0, P = shifted P − D (sub=1). Otherwise P = shifted P + D (sub=0).
  - Set A[0] = ~new P[32].
  - After count reaches WIDTH−1, go to FIX.
- **FIX**
  - If P[32] is 1, P = P + D.
  - Load quotient = A, remainder = P[31:0].
  - Go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then return to IDLE.
- **Add/subtract rule:** the operand is D zero-extended to 33 bits, XOR-ed with sub, with carry-in = sub. Carry-out is ignored. The result wraps modulo 2^33.
- **`start` while busy:** ignored. It is not queued.
- **`start` in the DONE cycle:** ignored. A new request is accepted from IDLE only.
- **Reset:** asynchronous `rst` at any time (including mid-RUN) forces state IDLE and clears P, A, D, count, `quotient`, `remainder`, `div_by_zero`, `busy` and `done` to 0. No done pulse is produced for the aborted operation.

## Timing

- **Edge 0:** `start` is sampled in IDLE. After edge 0, `busy`=1.
- **Normal division:**
  - Edges 1–32: iterations.
  - Edge 33: FIX, results registered.
  - `done`=1 in the cycle after edge 33, i.e. 34 cycles after the accepting edge.
  - Edge 34: back to IDLE, `busy`=0.
- **Divide by zero:**
  - `done`=1 in the cycle after edge 0.
  - `busy` drops after edge 1.
- **Back-to-back:** the earliest next accepted `start` is on the edge after `done` falls. The minimum issue interval is 35 cycles.
- **Output style:** all outputs are registered. There are no combinational paths from inputs to outputs.
- **Reset values:** every output is 0.

## Structure

- **Shared package `arith_pkg`:**
  - State enum `div_state_t` (IDLE, RUN, FIX, DONE).
  - Constant `DIV_W` = 32.
  - Constant `DIV_CNT_W` = 5.
  - Constant `ALL_ONES_Q`.
- **Sub-module `addsub33`:** one combinational 33-bit adder-subtractor, instantiated once and shared by RUN and FIX.
  - Ports: `a[32:0]`, `b[32:0]`, `sub`, `sum[32:0]`, `cout`.
  - Implementation: B XOR sub, carry-in = sub.
  - In FIX, `sub` is forced to 0.
- **Top level:** registers, counter, FSM and the output registers.

## Test plan

- **Basic:** dividend=100, divisor=7, `start` pulsed → `done` 34 cycles later with quotient=14, remainder=2, `div_by_zero`=0.
- **Dividend smaller than divisor:** dividend=5, divisor=10 → quotient=0, remainder=5. Also dividend=0xFFFFFFFF, divisor=1 → quotient=0xFFFFFFFF, remainder=0. Also dividend=0xFFFFFFFF, divisor=0xFFFFFFFF → quotient=1, remainder=0.
- **Divide by zero:** dividend=0x1234, divisor=0 → `done` one cycle after acceptance with quotient=0xFFFFFFFF, remainder=0x1234, `div_by_zero`=1.
- **Ignored start:** `start` with 9/3 asserted 10 cycles into a 100/7 run → 100/7 result unchanged, single `done`, `busy` falls at cycle 35. A new start then yields quotient=3, remainder=0.
- **Reset mid-operation:** `rst` asserted at cycle 15 of a run → all outputs 0 immediately (asynchronous), no `done` pulse. After release, a 50/8 division gives quotient=6, remainder=2.
- **Random:** 10k random operand pairs (including divisor=0), compared against a reference model of `/` and `%`, plus checks of `done` pulse width and latency.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-block definitions: divider FSM states and width constants.
package arith_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = 5;

    localparam logic [DIV_W-1:0] ALL_ONES_Q = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_t;

endpackage : arith_pkg

// File: rtl/addsub33.sv
// Combinational (WIDTH+1)-bit adder-subtractor: sum = a + (b ^ sub) + sub, modulo 2^(WIDTH+1).
module addsub33
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] sum,
    output logic           cout
);

    logic [WIDTH:0] b_eff;

    assign b_eff       = b ^ {(WIDTH + 1){sub}};
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + (WIDTH + 2)'(sub);

endmodule : addsub33

// File: rtl/seq_divider.sv
// Sequential unsigned non-restoring divider: one quotient bit per cycle through a
// shared adder-subtractor, followed by a single remainder-correction step.
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W  = (WIDTH == DIV_W) ? DIV_CNT_W : $clog2(WIDTH);
    localparam logic [WIDTH-1:0] Q_ONES = (WIDTH == DIV_W) ? WIDTH'(ALL_ONES_Q) : {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);

    div_state_t       state, state_n;
    logic [WIDTH:0]   p_reg, p_n;
    logic [WIDTH-1:0] a_reg, a_n;
    logic [WIDTH-1:0] d_reg, d_n;
    logic [CNT_W-1:0] count, count_n;
    logic [WIDTH-1:0] quotient_n, remainder_n;
    logic             div_by_zero_n, busy_n, done_n;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   add_a, add_b, sum;
    logic             add_sub;
    logic             unused_cout;

    assign p_shift = {p_reg[WIDTH-1:0], a_reg[WIDTH-1]};
    assign add_b   = {1'b0, d_reg};

    // RUN picks the operation from the pre-shift remainder sign; FIX only ever adds back.
    always_comb begin
        add_a   = p_reg;
        add_sub = 1'b0;
        if (state == RUN) begin
            add_a   = p_shift;
            add_sub = ~p_reg[WIDTH];
        end
    end

    addsub33 #(.WIDTH(WIDTH)) u_addsub (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .sum  (sum),
        .cout (unused_cout)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_n       = state;
        p_n           = p_reg;
        a_n           = a_reg;
        d_n           = d_reg;
        count_n       = count;
        quotient_n    = quotient;
        remainder_n   = remainder;
        div_by_zero_n = div_by_zero;
        busy_n        = busy;
        done_n        = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    d_n     = divisor;
                    a_n     = dividend;
                    p_n     = '0;
                    count_n = '0;
                    busy_n  = 1'b1;
                    if (divisor == '0) begin
                        quotient_n    = Q_ONES;
                        remainder_n   = dividend;
                        div_by_zero_n = 1'b1;
                        done_n        = 1'b1;
                        state_n       = DONE;
                    end else begin
                        div_by_zero_n = 1'b0;
                        state_n       = RUN;
                    end
                end
            end
            RUN: begin
                p_n     = sum;
                a_n     = {a_reg[WIDTH-2:0], ~sum[WIDTH]};
                count_n = count + 1'b1;
                if (count == LAST) state_n = FIX;
            end
            FIX: begin
                if (p_reg[WIDTH]) p_n = sum;
                quotient_n  = a_reg;
                remainder_n = p_reg[WIDTH] ? sum[WIDTH-1:0] : p_reg[WIDTH-1:0];
                done_n      = 1'b1;
                state_n     = DONE;
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            p_reg       <= '0;
            a_reg       <= '0;
            d_reg       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            p_reg       <= p_n;
            a_reg       <= a_n;
            d_reg       <= d_n;
            count       <= count_n;
            quotient    <= quotient_n;
            remainder   <= remainder_n;
            div_by_zero <= div_by_zero_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: results, latency, handshake, reset abort.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One division; poke_at >= 0 raises an ignored 9/3 start that many cycles in,
    // poke_done raises an ignored start during the done cycle.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic [31:0] exp_r,
                           input logic exp_z, input int poke_at, input bit poke_done);
        int lat;
        string t;
        t = $sformatf("%0h/%0h", a, b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
        check({t, " busy"}, 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
            start = (lat == poke_at);
            if (start) begin
                dividend = 32'd9;
                divisor  = 32'd3;
            end
        end
        start = 1'b0;
        check({t, " latency"}, 64'(lat), (exp_z ? 64'd0 : 64'd33));
        check({t, " quotient"}, 64'(quotient), 64'(exp_q));
        check({t, " remainder"}, 64'(remainder), 64'(exp_r));
        check({t, " div_by_zero"}, 64'(div_by_zero), 64'(exp_z));
        if (poke_done) begin
            start    = 1'b1;
            dividend = 32'd9;
            divisor  = 32'd3;
        end
        @(negedge clk);
        start = 1'b0;
        check({t, " done width"}, 64'(done), 64'd0);
        check({t, " busy after"}, 64'(busy), 64'd0);
        if (poke_at >= 0 || poke_done) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check({t, " no extra op"}, {62'd0, busy, done}, 64'd0);
            end
            check({t, " quotient held"}, 64'(quotient), 64'(exp_q));
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen_done;
        repeat (3) @(negedge clk);
        check("reset outputs", {quotient, remainder}, 64'd0);
        check("reset flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, -1, 1'b0);
        run_div(32'd5, 32'd10, 32'd0, 32'd5, 1'b0, -1, 1'b0);
        run_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, -1, 1'b0);
        run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, -1, 1'b0);
        run_div(32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, -1, 1'b0);
        run_div(32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, -1, 1'b0);
        run_div(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, -1, 1'b0);
        run_div(32'd7, 32'd7, 32'd1, 32'd0, 1'b0, -1, 1'b0);
        run_div(32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b0, -1, 1'b0);
        run_div(32'hDEAD_BEEF, 32'h10, 32'h0DEA_DBEE, 32'hF, 1'b0, -1, 1'b0);
        run_div(32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, -1, 1'b0);
        run_div(32'h1234_5678, 32'h1000, 32'h0001_2345, 32'h678, 1'b0, -1, 1'b0);
        run_div(32'd123456789, 32'd10000, 32'd12345, 32'd6789, 1'b0, -1, 1'b0);
        run_div(32'd1000000, 32'd1000, 32'd1000, 32'd0, 1'b0, -1, 1'b0);

        run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 10, 1'b0);
        run_div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, -1, 1'b0);
        run_div(32'd5, 32'd10, 32'd0, 32'd5, 1'b0, -1, 1'b1);
        run_div(32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, -1, 1'b1);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort outputs", {quotient, remainder}, 64'd0);
        check("abort flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        seen_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 3) rst = 1'b0;
            seen_done += int'(done);
        end
        check("abort no done", 64'(seen_done), 64'd0);
        run_div(32'd50, 32'd8, 32'd6, 32'd2, 1'b0, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seq_divider
